// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, word width,
// default NOP encoding and the buffered {instr, pc} entry layout.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [INSTR_W-1:0] pc;
    } fetch_entry_t;

    function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Small FIFO holding fetched {instr, pc} entries between memory and decode.
// Flush wins over push and pop; control state is reset, storage is not.
module fetch_buf #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SLOTS = 1 << PTR_W;

    logic [WIDTH-1:0] mem [SLOTS];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1))
            return '0;
        return p + 1'b1;
    endfunction

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)
                rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch.sv
// Instruction fetch: one outstanding imem request, redirect flush, output FIFO.
// Define FETCH_SKID_BUF_EN for a 2-entry buffer; default build uses 1 entry.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid
);

`ifdef FETCH_SKID_BUF_EN
    localparam int BUF_DEPTH = 2;
`else
    localparam int BUF_DEPTH = 1;
`endif
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    fetch_state_t     state;
    fetch_state_t     state_n;
    logic [31:0]      pc;
    logic [31:0]      pc_n;
    logic [31:0]      last_pc;
    logic [31:0]      redirect_aligned;
    logic             armed;
    logic             push;
    logic             pop;
    logic             buf_full;
    logic             buf_empty;
    logic             buf_free;
    logic             space_after;
    logic [CNT_W-1:0] buf_count;
    logic [CNT_W:0]   occ_after;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    assign redirect_aligned = word_align(redirect_pc);
    assign pop              = !buf_empty && !stall;
    assign buf_free         = !buf_full || pop;
    assign occ_after        = (CNT_W+1)'(buf_count) + (CNT_W+1)'(1) - (CNT_W+1)'(pop);
    assign space_after      = occ_after < (CNT_W+1)'(BUF_DEPTH);
    assign push_entry       = '{instr: imem_rdata, pc: pc};

    // armed delays the first request by one edge after reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            pc      <= word_align(RESET_PC);
            last_pc <= word_align(RESET_PC);
            armed   <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            armed <= 1'b1;
            if (!buf_empty)
                last_pc <= head.pc;
        end
    end

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        push     = 1'b0;
        imem_req = 1'b0;
        case (state)
            ST_IDLE: begin
                if (redirect)
                    pc_n = redirect_aligned;
                else if (armed && buf_free)
                    state_n = ST_REQ;
            end
            ST_REQ: begin
                imem_req = 1'b1;
                if (redirect) begin
                    pc_n    = redirect_aligned;
                    state_n = ST_DRAIN;
                end else begin
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    pc_n    = redirect_aligned;
                    state_n = imem_ack ? ST_REQ : ST_DRAIN;
                end else if (imem_ack) begin
                    push    = 1'b1;
                    pc_n    = pc + 32'd4;
                    state_n = space_after ? ST_REQ : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // the pending ack belongs to a flushed request and is dropped
                if (redirect)
                    pc_n = redirect_aligned;
                if (imem_ack)
                    state_n = ST_REQ;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    fetch_buf #(
        .DEPTH (BUF_DEPTH),
        .WIDTH ($bits(fetch_entry_t)),
        .CNT_W (CNT_W)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   (push_entry),
        .dout  (head),
        .full  (buf_full),
        .empty (buf_empty),
        .count (buf_count)
    );

    assign imem_addr   = pc;
    assign instr_valid = !buf_empty;
    assign instr       = buf_empty ? NOP_INSTR : head.instr;
    assign instr_pc    = buf_empty ? last_pc : head.pc;

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: sequential fetch, stall backpressure, redirects,
// reset during an outstanding request and PC wrap-around.
module tb_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;

    int vectors;
    int miscompares;

    fetch dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic ack_word(input logic [31:0] d);
        imem_ack   = 1'b1;
        imem_rdata = d;
        step();
        imem_ack   = 1'b0;
        imem_rdata = '0;
    endtask

    // From the cycle an instruction was just delivered (stall low) to the
    // next WAIT cycle with an empty buffer, checking the next request address.
    task automatic next_wait(input logic [31:0] a);
`ifdef FETCH_SKID_BUF_EN
        chk1("nw_req", imem_req, 1'b1);
        chk("nw_addr", imem_addr, a);
        step();
`else
        step();
        chk1("nw_req", imem_req, 1'b1);
        chk("nw_addr", imem_addr, a);
        step();
`endif
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        stall       = 1'b0;

        // asynchronous reset, checked before any clock edge
        #2 rst = 1'b1;
        #1;
        chk1("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_ipc", instr_pc, 32'h0);
        chk1("rst_valid", instr_valid, 1'b0);
        step();
        step();
        rst = 1'b0;

        // sequential fetch 0x0, 0x4, 0x8
        step();
        chk1("e1_req", imem_req, 1'b0);
        step();
        chk1("e2_req", imem_req, 1'b1);
        chk("e2_addr", imem_addr, 32'h0);
        step();
        chk1("e3_req", imem_req, 1'b0);
        chk1("e3_valid", instr_valid, 1'b0);
        ack_word(32'h1111_1111);
        chk1("a0_valid", instr_valid, 1'b1);
        chk("a0_instr", instr, 32'h1111_1111);
        chk("a0_pc", instr_pc, 32'h0);
        next_wait(32'h4);
        ack_word(32'h2222_2222);
        chk("a1_instr", instr, 32'h2222_2222);
        chk("a1_pc", instr_pc, 32'h4);
        next_wait(32'h8);
        ack_word(32'h3333_3333);
        chk("a2_instr", instr, 32'h3333_3333);
        chk("a2_pc", instr_pc, 32'h8);

        // decode stalls for 5 cycles
`ifdef FETCH_SKID_BUF_EN
        chk1("sk_req", imem_req, 1'b1);
        chk("sk_addr", imem_addr, 32'hC);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            imem_ack   = (i == 1);
            imem_rdata = (i == 1) ? 32'h4444_4444 : 32'h0;
            step();
            chk("st_instr", instr, 32'h3333_3333);
            chk("st_pc", instr_pc, 32'h8);
            chk1("st_valid", instr_valid, 1'b1);
            chk1("st_req", imem_req, 1'b0);
        end
        imem_ack   = 1'b0;
        imem_rdata = '0;
        stall      = 1'b0;
        step();
        chk("rl_instr", instr, 32'h4444_4444);
        chk("rl_pc", instr_pc, 32'hC);
        chk1("rl_req", imem_req, 1'b1);
        chk("rl_addr", imem_addr, 32'h10);
        step();
        chk1("rl_empty", instr_valid, 1'b0);
`else
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("st_instr", instr, 32'h3333_3333);
            chk("st_pc", instr_pc, 32'h8);
            chk1("st_valid", instr_valid, 1'b1);
            chk1("st_req", imem_req, 1'b0);
        end
        stall = 1'b0;
        step();
        chk1("rl_valid", instr_valid, 1'b0);
        chk1("rl_req", imem_req, 1'b1);
        chk("rl_addr", imem_addr, 32'hC);
        step();
        ack_word(32'h4444_4444);
        chk("rl_instr", instr, 32'h4444_4444);
        chk("rl_pc", instr_pc, 32'hC);
        next_wait(32'h10);
`endif

        // redirect in WAIT, late ack of 0xDEADBEEF must be dropped
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect    = 1'b0;
        chk1("rd_valid", instr_valid, 1'b0);
        chk1("rd_req", imem_req, 1'b0);
        chk("rd_addr", imem_addr, 32'h100);
        step();
        chk1("dr_req", imem_req, 1'b0);
        ack_word(32'hDEAD_BEEF);
        chk1("dr_valid", instr_valid, 1'b0);
        chk("dr_instr", instr, 32'h0000_0013);
        chk1("dr_req2", imem_req, 1'b1);
        chk("dr_addr", imem_addr, 32'h100);
        step();
        chk("dr_instr2", instr, 32'h0000_0013);
        ack_word(32'h5555_5555);
        chk("r1_instr", instr, 32'h5555_5555);
        chk("r1_pc", instr_pc, 32'h100);
        next_wait(32'h104);

        // redirect to unaligned 0x203 together with ack
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        imem_ack    = 1'b1;
        imem_rdata  = 32'hBADB_AD00;
        step();
        redirect    = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        chk1("ra_valid", instr_valid, 1'b0);
        chk("ra_instr", instr, 32'h0000_0013);
        chk("ra_ipc", instr_pc, 32'h100);
        chk1("ra_req", imem_req, 1'b1);
        chk("ra_addr", imem_addr, 32'h200);
        step();

        // reset while WAITing, stale ack after release
        rst = 1'b1;
        #1;
        chk1("rw_req", imem_req, 1'b0);
        chk("rw_addr", imem_addr, 32'h0);
        chk("rw_ipc", instr_pc, 32'h0);
        chk1("rw_valid", instr_valid, 1'b0);
        step();
        rst        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAAD_F00D;
        step();
        chk1("sa_valid1", instr_valid, 1'b0);
        chk1("sa_req1", imem_req, 1'b0);
        step();
        chk1("sa_valid2", instr_valid, 1'b0);
        chk1("sa_req2", imem_req, 1'b1);
        chk("sa_addr2", imem_addr, 32'h0);
        step();
        imem_ack   = 1'b0;
        imem_rdata = '0;
        chk1("sa_valid3", instr_valid, 1'b0);
        step();
        chk1("sa_valid4", instr_valid, 1'b0);
        ack_word(32'h8888_8888);
        chk("sa_instr", instr, 32'h8888_8888);
        chk("sa_pc", instr_pc, 32'h0);
        next_wait(32'h4);

        // fetch from 0xFFFF_FFFC wraps to 0
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect    = 1'b0;
        chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
        chk1("wr_req", imem_req, 1'b0);
        ack_word(32'h7777_7777);
        chk1("wr_req2", imem_req, 1'b1);
        chk("wr_addr2", imem_addr, 32'hFFFF_FFFC);
        chk1("wr_valid", instr_valid, 1'b0);
        step();
        ack_word(32'h6666_6666);
        chk("wr_instr", instr, 32'h6666_6666);
        chk("wr_pc", instr_pc, 32'hFFFF_FFFC);
        next_wait(32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address of first fetch after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), word driven on instr when no valid instruction is held.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  32  byte address of the request, word-aligned.
REQ-007 imem_ack  input  1  read data valid this cycle; answers the single outstanding request.
REQ-008 imem_rdata  input  32  instruction word, qualified by imem_ack.
REQ-009 redirect  input  1  taken branch/jump from a later stage; flush and refetch.
REQ-010 redirect_pc  input  32  new fetch address, qualified by redirect.
REQ-011 stall  input  1  downstream decode cannot accept an instruction this cycle.
REQ-012 instr  output  32  instruction presented to decode (next_instruction).
REQ-013 instr_pc  output  32  byte address of instr (decode PC input).
REQ-014 instr_valid  output  1  instr/instr_pc hold a real fetched instruction.

Function
REQ-015 FSM states: IDLE, REQ, WAIT, DRAIN; at most one memory request outstanding.
REQ-016 IDLE: go to REQ when buffer has a free entry and redirect is low.
REQ-017 REQ: imem_req=1, imem_addr=pc for exactly one cycle, then WAIT.
REQ-018 WAIT: on imem_ack, write {imem_rdata, pc} into the buffer, pc<=pc+4 (modulo 2^32), then REQ if space remains after that cycle's pop, else IDLE.
REQ-019 Redirect in REQ or WAIT without same-cycle imem_ack: pc<=redirect_pc, buffer flushed, state DRAIN; the next imem_ack is discarded, then REQ.
REQ-020 Redirect in WAIT coinciding with imem_ack: returned word discarded, pc<=redirect_pc, buffer flushed, state REQ.
REQ-021 Redirect in IDLE or DRAIN: pc<=redirect_pc, buffer flushed; state unchanged (DRAIN still awaits its ack).
REQ-022 redirect_pc[1:0] ignored; fetch address forced word-aligned.
REQ-023 Buffer is FIFO of {instr, pc}; instr_valid = not empty; instr/instr_pc = head entry.
REQ-024 Pop when instr_valid && !stall; push and pop in the same cycle permitted when full.
REQ-025 Empty buffer: instr=NOP_INSTR, instr_pc=last pc presented, instr_valid=0.
REQ-026 Redirect has priority over push and pop in the same cycle; no instruction from before the redirect reaches instr afterwards.
REQ-027 Latency: first instr_valid no earlier than 2 cycles after the imem_req that fetched it (REQ cycle, ack cycle, registered output).

Reset
REQ-028 Asynchronous assert: state=IDLE, pc=RESET_PC, buffer empty, imem_req=0, imem_addr=RESET_PC, instr=NOP_INSTR, instr_pc=RESET_PC, instr_valid=0.
REQ-029 Reset mid-WAIT: outstanding request forgotten; an imem_ack arriving after release while in IDLE/REQ is ignored.
REQ-030 First imem_req no earlier than the second rising clk edge after rst deasserts.

Configuration
REQ-031 Macro FETCH_SKID_BUF_EN defined: buffer depth 2, allowing a new request while decode is stalled on one held instruction.
REQ-032 FETCH_SKID_BUF_EN undefined: buffer depth 1; no request issued while the single entry is occupied and not popping.

Structure
REQ-033 Shared package holds FSM state encoding, NOP_INSTR value, and instruction width constant (32).
REQ-034 Buffer is sub-module fetch_buf (parameterised depth, push/pop/flush, full/empty).

Verification
REQ-035 Reset, ack every WAIT cycle, stall=0 -> imem_addr 0x0,0x4,0x8; instr_pc sequence 0x0,0x4,0x8 with matching imem_rdata.
REQ-036 stall=1 for 5 cycles with FETCH_SKID_BUF_EN -> exactly 2 entries buffered, imem_req stops, instr unchanged; release -> both delivered in order.
REQ-037 redirect to 0x100 during WAIT, ack 2 cycles later with 0xDEADBEEF -> 0xDEADBEEF never on instr; next imem_addr=0x100.
REQ-038 redirect to 0x203 same cycle as imem_ack -> word dropped, buffer empty, next imem_addr=0x200.
REQ-039 rst pulsed in WAIT, stale ack after release -> instr_valid stays 0 until fresh fetch of RESET_PC.
REQ-040 pc=0xFFFF_FFFC fetched -> next imem_addr=0x0000_0000.
